// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shift-type constants, FSM states and operand forms (SHIFT_BY_REG_EN)
package shifter_pkg;

    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

`ifdef SHIFT_BY_REG_EN
    typedef enum logic [1:0] {IDLE, RS_WAIT, OUT} state_t;
`else
    typedef enum logic [1:0] {IDLE, OUT} state_t;
`endif

    typedef enum logic [1:0] {IMM_ROT, IMM_SHIFT, REG_SHIFT, ILLEGAL} form_t;

    function automatic form_t decode_form(input logic [31:0] ins);
        if (ins[25]) return IMM_ROT;
        if (!ins[4]) return IMM_SHIFT;
        if (!ins[7]) return REG_SHIFT;
        return ILLEGAL;
    endfunction

endpackage

// File: rtl/barrel_core.sv
// rtl/barrel_core.sv - combinational ARM shifter for amounts 0..255
module barrel_core
    import shifter_pkg::*;
(
    input  logic [31:0] rm,
    input  logic [1:0]  shift_type,
    input  logic [7:0]  amount,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        carry
);

    logic [4:0]  k;
    logic [4:0]  lsl_idx;
    logic [4:0]  r_idx;
    logic [31:0] rot;

    always_comb begin
        k       = amount[4:0];
        lsl_idx = 5'(6'd32 - {1'b0, k});
        r_idx   = k - 5'd1;
        rot     = (rm >> k) | (rm << (6'd32 - {1'b0, k}));
        result  = rm;
        carry   = carry_in;
        if (amount != 8'd0) begin
            case (shift_type)
                SHIFT_LSL: begin
                    if (amount < 8'd32) begin
                        result = rm << k;
                        carry  = rm[lsl_idx];
                    end else begin
                        result = 32'd0;
                        carry  = (amount == 8'd32) ? rm[0] : 1'b0;
                    end
                end
                SHIFT_LSR: begin
                    if (amount < 8'd32) begin
                        result = rm >> k;
                        carry  = rm[r_idx];
                    end else begin
                        result = 32'd0;
                        carry  = (amount == 8'd32) ? rm[31] : 1'b0;
                    end
                end
                SHIFT_ASR: begin
                    if (amount < 8'd32) begin
                        result = $signed(rm) >>> k;
                        carry  = rm[r_idx];
                    end else begin
                        result = {32{rm[31]}};
                        carry  = rm[31];
                    end
                end
                default: begin
                    // Multiples of 32 leave Rm in place but still report bit 31 as carry
                    if (k == 5'd0) begin
                        result = rm;
                        carry  = rm[31];
                    end else begin
                        result = rot;
                        carry  = rm[r_idx];
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/shifter_operand_unit.sv
// rtl/shifter_operand_unit.sv - addressing-mode-1 operand producer; SHIFT_BY_REG_EN enables Rs-shift form
module shifter_operand_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rm_data,
    input  logic              carry_in,
    output logic              rs_rd_req,
    output logic [3:0]        rs_rd_addr,
    input  logic              rs_rd_ack,
    input  logic [DATA_W-1:0] rs_rd_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_out,
    output logic              op_carry,
    output logic              op_illegal
);
    import shifter_pkg::*;

    state_t      state, state_nxt;
    form_t       form;
    logic [31:0] bc_rm, bc_result;
    logic [1:0]  bc_type;
    logic [7:0]  bc_amt;
    logic        bc_cin, bc_carry;
    logic [31:0] res_op;
    logic        res_carry, res_illegal;
    logic        op_load, cap_load, needs_rs, is_illegal;

    assign form = decode_form(instr);

`ifdef SHIFT_BY_REG_EN
    logic [31:0] cap_rm;
    logic [1:0]  cap_type;
    logic        cap_carry;
    logic [3:0]  cap_rs_idx;
    logic        unused_bits;

    assign needs_rs    = (form == REG_SHIFT);
    assign is_illegal  = (form == ILLEGAL);
    assign rs_rd_req   = (state == RS_WAIT);
    assign rs_rd_addr  = rs_rd_req ? cap_rs_idx : 4'd0;
    assign unused_bits = ^{instr[31:26], instr[24:12], rs_rd_data[31:8]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_rm     <= 32'd0;
            cap_type   <= 2'd0;
            cap_carry  <= 1'b0;
            cap_rs_idx <= 4'd0;
        end else if (cap_load) begin
            cap_rm     <= rm_data;
            cap_type   <= instr[6:5];
            cap_carry  <= carry_in;
            cap_rs_idx <= instr[11:8];
        end
    end
`else
    logic unused_bits;

    // Register-shift encodings are reported as illegal when Rs reads are not built in
    assign needs_rs    = 1'b0;
    assign is_illegal  = (form == ILLEGAL) || (form == REG_SHIFT);
    assign rs_rd_req   = 1'b0;
    assign rs_rd_addr  = 4'd0;
    assign unused_bits = ^{instr[31:26], instr[24:12], rs_rd_ack, rs_rd_data, cap_load};
`endif

    always_comb begin
        bc_rm   = rm_data;
        bc_type = instr[6:5];
        bc_amt  = {3'b000, instr[11:7]};
        bc_cin  = carry_in;
`ifdef SHIFT_BY_REG_EN
        if (state == RS_WAIT) begin
            bc_rm   = cap_rm;
            bc_type = cap_type;
            bc_amt  = rs_rd_data[7:0];
            bc_cin  = cap_carry;
        end else
`endif
        if (form == IMM_ROT) begin
            bc_rm   = {24'd0, instr[7:0]};
            bc_type = SHIFT_ROR;
            bc_amt  = {3'b000, instr[11:8], 1'b0};
        end else if (form == IMM_SHIFT && instr[11:7] == 5'd0 && instr[6:5] != SHIFT_LSL) begin
            // LSR#0 and ASR#0 encode a shift by 32; ROR#0 (RRX) is patched below
            bc_amt = 8'd32;
        end
    end

    always_comb begin
        res_op      = bc_result;
        res_carry   = bc_carry;
        res_illegal = 1'b0;
        state_nxt   = state;
        op_load     = 1'b0;
        cap_load    = 1'b0;
        if (state == IDLE) begin
            if (is_illegal) begin
                res_op      = 32'd0;
                res_carry   = carry_in;
                res_illegal = 1'b1;
            end else if (form == IMM_SHIFT && instr[11:7] == 5'd0 && instr[6:5] == SHIFT_ROR) begin
                res_op    = {carry_in, rm_data[31:1]};
                res_carry = rm_data[0];
            end
        end
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    if (needs_rs) begin
                        cap_load  = 1'b1;
`ifdef SHIFT_BY_REG_EN
                        state_nxt = RS_WAIT;
`endif
                    end else begin
                        op_load   = 1'b1;
                        state_nxt = OUT;
                    end
                end
            end
`ifdef SHIFT_BY_REG_EN
            RS_WAIT: begin
                if (rs_rd_ack) begin
                    op_load   = 1'b1;
                    state_nxt = OUT;
                end
            end
`endif
            OUT: begin
                if (op_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_out     <= '0;
            op_carry   <= 1'b0;
            op_illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (op_load) begin
                op_out     <= res_op;
                op_carry   <= res_carry;
                op_illegal <= res_illegal;
            end
        end
    end

    assign instr_ready = (state == IDLE);
    assign op_valid    = (state == OUT);

    barrel_core u_barrel_core (
        .rm         (bc_rm),
        .shift_type (bc_type),
        .amount     (bc_amt),
        .carry_in   (bc_cin),
        .result     (bc_result),
        .carry      (bc_carry)
    );

endmodule

// File: tb/tb_shifter_operand_unit.sv
// tb/tb_shifter_operand_unit.sv - self-checking bench for shifter_operand_unit (SHIFT_BY_REG_EN aware)
module tb_shifter_operand_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic [31:0] rm_data = 32'd0;
    logic        carry_in = 1'b0;
    logic        rs_rd_req;
    logic [3:0]  rs_rd_addr;
    logic        rs_rd_ack = 1'b0;
    logic [31:0] rs_rd_data = 32'd0;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [31:0] op_out;
    logic        op_carry;
    logic        op_illegal;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    shifter_operand_unit #(.DATA_W(32)) dut (
        .clk         (clk),
        .reset       (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rm_data     (rm_data),
        .carry_in    (carry_in),
        .rs_rd_req   (rs_rd_req),
        .rs_rd_addr  (rs_rd_addr),
        .rs_rd_ack   (rs_rd_ack),
        .rs_rd_data  (rs_rd_data),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_out      (op_out),
        .op_carry    (op_carry),
        .op_illegal  (op_illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic needs_rs(input logic [31:0] ins);
`ifdef SHIFT_BY_REG_EN
        return !ins[25] && ins[4] && !ins[7];
`else
        return 1'b0;
`endif
    endfunction

    // Reference: shift one bit at a time, carry is the last bit shifted out
    function automatic logic [33:0] model(input logic [31:0] ins, input logic [31:0] rm,
                                          input logic c, input logic [31:0] rs);
        logic [31:0] v;
        logic        cy;
        int          n;
        logic [1:0]  t;
        cy = c;
        if (ins[25]) begin
            v = {24'd0, ins[7:0]};
            n = 2 * int'(ins[11:8]);
            t = 2'b11;
        end else if (!ins[4]) begin
            v = rm;
            n = int'(ins[11:7]);
            t = ins[6:5];
            if (n == 0 && t == 2'b11) return {1'b0, rm[0], c, rm[31:1]};
            if (n == 0 && t != 2'b00) n = 32;
        end else if (needs_rs(ins)) begin
            v = rm;
            n = int'(rs[7:0]);
            t = ins[6:5];
        end else begin
            return {1'b1, c, 32'd0};
        end
        for (int i = 0; i < n; i++) begin
            case (t)
                2'b00:   begin cy = v[31]; v = v << 1; end
                2'b01:   begin cy = v[0];  v = v >> 1; end
                2'b10:   begin cy = v[0];  v = {v[31], v[31:1]}; end
                default: begin cy = v[0];  v = {v[0], v[31:1]}; end
            endcase
        end
        return {1'b0, cy, v};
    endfunction

    function automatic logic [31:0] mk_imm(input logic [4:0] n, input logic [1:0] t);
        return 32'hE1A00000 | {20'd0, n, t, 5'd0};
    endfunction

    function automatic logic [31:0] mk_reg(input logic [1:0] t);
        return 32'hE1A00000 | {20'd0, 4'h1, 1'b0, t, 1'b1, 4'h0};
    endfunction

    always @(negedge clk) begin
        if (!rst && op_valid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_op_valid: got op_out %h with no pending result", op_out);
            end else begin
                chk("op_out", op_out, exp_q[0][31:0]);
                chk("op_carry", op_carry, exp_q[0][32]);
                chk("op_illegal", op_illegal, exp_q[0][33]);
                if (op_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] rmv, input logic c,
                        input logic [31:0] rs, input int ack_delay, input int hold);
        logic need;
        need = needs_rs(ins);
        instr = ins; rm_data = rmv; carry_in = c; instr_valid = 1'b1;
        chk("instr_ready_idle", instr_ready, 1);
        exp_q.push_back(model(ins, rmv, c, rs));
        @(posedge clk); #1;
        instr_valid = 1'b0; instr = $urandom; rm_data = $urandom; carry_in = ~c;
        if (need) begin
            for (int i = 0; i <= ack_delay; i++) begin
                chk("rs_rd_req", rs_rd_req, 1);
                chk("rs_rd_addr", rs_rd_addr, ins[11:8]);
                chk("op_valid_in_wait", op_valid, 0);
                if (i < ack_delay) begin @(posedge clk); #1; end
            end
            rs_rd_ack = 1'b1; rs_rd_data = rs;
            @(posedge clk); #1;
            rs_rd_ack = 1'b0; rs_rd_data = $urandom;
        end else begin
            chk("no_rs_rd_req", rs_rd_req, 0);
        end
        chk("op_valid_latency", op_valid, 1);
        chk("instr_ready_busy", instr_ready, 0);
        for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
        op_ready = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
        chk("op_valid_drop", op_valid, 0);
        chk("rs_rd_req_after", rs_rd_req, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [33:0] m;

        m = model(32'hE3A004FF, 32'h12345678, 1'b0, 32'd0);
        chk("pin_rotimm", m[31:0], 32'hFF000000); chk("pin_rotimm_c", m[32], 1);
        m = model(32'hE1A00061, 32'h00000003, 1'b1, 32'd0);
        chk("pin_rrx", m[31:0], 32'h80000001); chk("pin_rrx_c", m[32], 1);
        m = model(32'hE0000091, 32'h5, 1'b1, 32'd0);
        chk("pin_illegal", m, {1'b1, 1'b1, 32'd0});
`ifdef SHIFT_BY_REG_EN
        m = model(32'hE1A00130, 32'h80000000, 1'b0, 32'd32);
        chk("pin_lsr32", m, {1'b0, 1'b1, 32'd0});
        m = model(32'hE1A00130, 32'h80000000, 1'b0, 32'd33);
        chk("pin_lsr33", m, {1'b0, 1'b0, 32'd0});
        m = model(32'hE1A00170, 32'h80000001, 1'b0, 32'h120);
        chk("pin_ror32", m, {1'b0, 1'b1, 32'h80000001});
`else
        m = model(32'hE1A00130, 32'h80000000, 1'b0, 32'd32);
        chk("pin_reg_illegal", m, {1'b1, 1'b0, 32'd0});
`endif

        #1;
        chk("rst_instr_ready", instr_ready, 1);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_rs_rd_req", rs_rd_req, 0);
        chk("rst_op_out", op_out, 0);
        chk("rst_op_carry", op_carry, 0);
        chk("rst_op_illegal", op_illegal, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        send(32'hE3A004FF, 32'h12345678, 1'b0, 32'd0, 0, 0);
        send(32'hE1A00061, 32'h00000003, 1'b1, 32'd0, 0, 0);
        send(32'hE3A000AB, 32'h0, 1'b1, 32'd0, 0, 1);
        send(mk_imm(5'd4, 2'b00), 32'hF000000F, 1'b0, 32'd0, 0, 0);
        send(mk_imm(5'd0, 2'b01), 32'h80000000, 1'b0, 32'd0, 0, 0);
        send(mk_imm(5'd0, 2'b10), 32'h80000001, 1'b0, 32'd0, 0, 0);
        send(mk_imm(5'd8, 2'b11), 32'h12345678, 1'b1, 32'd0, 0, 0);
        send(mk_imm(5'd31, 2'b10), 32'h7FFFFFFF, 1'b1, 32'd0, 0, 2);
        send(mk_reg(2'b01), 32'h80000000, 1'b0, 32'd32, 2, 0);
        send(mk_reg(2'b01), 32'h80000000, 1'b0, 32'd33, 1, 0);
        send(mk_reg(2'b11), 32'h80000001, 1'b0, 32'h120, 1, 3);
        send(mk_reg(2'b00), 32'h000000A5, 1'b1, 32'h00000000, 0, 0);
        send(mk_reg(2'b00), 32'h00000001, 1'b0, 32'd32, 0, 0);
        send(mk_reg(2'b00), 32'hFFFFFFFF, 1'b0, 32'd40, 0, 0);
        send(mk_reg(2'b00), 32'h00000003, 1'b0, 32'd31, 0, 0);
        send(mk_reg(2'b10), 32'h80000000, 1'b0, 32'd200, 0, 0);
        send(mk_reg(2'b11), 32'h0000000F, 1'b0, 32'd36, 0, 0);
        send(mk_reg(2'b01), 32'h00000003, 1'b0, 32'h0001FF01, 0, 0);
        send(32'hE0000091, 32'h00001234, 1'b1, 32'd0, 0, 0);

        // Reset while a transaction is outstanding
        instr = mk_reg(2'b01); rm_data = 32'h80000000; carry_in = 1'b0; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
`ifdef SHIFT_BY_REG_EN
        chk("pre_rst_rs_rd_req", rs_rd_req, 1);
`else
        chk("pre_rst_op_valid", op_valid, 1);
`endif
        rst = 1'b1;
        #1;
        chk("arst_rs_rd_req", rs_rd_req, 0);
        chk("arst_op_valid", op_valid, 0);
        chk("arst_instr_ready", instr_ready, 1);
        chk("arst_op_illegal", op_illegal, 0);
        @(posedge clk); #1; rst = 1'b0;
        rs_rd_ack = 1'b1; rs_rd_data = 32'd32;
        @(posedge clk); #1; rs_rd_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_ack_op_valid", op_valid, 0);
            chk("late_ack_instr_ready", instr_ready, 1);
            @(posedge clk); #1;
        end

        send(32'hE3A004FF, 32'h0, 1'b0, 32'd0, 0, 0);
        send(mk_reg(2'b10), 32'h40000000, 1'b1, 32'd1, 1, 1);
        @(posedge clk); #1;
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
